// File: rtl/sec_tick_gen_pkg.sv
// Shared definitions for the clock-setting logic: default dividers, the 2-bit
// set-key state encoding and a counter-width helper.
package sec_tick_gen_pkg;

  localparam int unsigned DEF_DIV_1HZ  = 50_000_000;
  localparam int unsigned DEF_DB_CYC   = 1_000_000;
  localparam int unsigned DEF_HOLD_CYC = 25_000_000;
  localparam int unsigned DEF_DIV_FAST = 6_250_000;

  // Encoding is shared with the minutes/hours setting logic; keep values fixed.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_PRESS  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_REPEAT = 2'd3
  } set_state_e;

  function automatic int cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sec_tick_gen_key_debounce.sv
// Push-button conditioner: 2-flop synchronizer (active-low key to active-high)
// followed by a stable-count debouncer with a one-cycle rising-edge strobe.
module key_debounce
  import sec_tick_gen_pkg::*;
#(
  parameter int unsigned DB_CYC = DEF_DB_CYC
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic keydb_o,
  output logic rise_o
);

  localparam int DBW = cnt_width(DB_CYC);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYC - 1);

  logic           sync1_q, sync2_q;
  logic [DBW-1:0] dbcnt_q, dbcnt_d;
  logic           keydb_q, keydb_d;
  logic           rise_q, rise_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dbcnt_q <= '0;
      keydb_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= ~key_ni;
      sync2_q <= sync1_q;
      dbcnt_q <= dbcnt_d;
      keydb_q <= keydb_d;
      rise_q  <= rise_d;
    end
  end

  // The counter only runs while the synced level disagrees with the accepted one.
  always_comb begin
    dbcnt_d = '0;
    keydb_d = keydb_q;
    rise_d  = 1'b0;
    if (sync2_q != keydb_q) begin
      if (dbcnt_q == DB_LAST) begin
        keydb_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        dbcnt_d = dbcnt_q + DBW'(1);
      end
    end
  end

  assign keydb_o = keydb_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/sec_tick_gen.sv
// Seconds-counter timing source: 1 Hz prescaler plus debounced set key with
// single-step and auto-repeat, merged into one count-enable strobe.
module sec_tick_gen
  import sec_tick_gen_pkg::*;
#(
  parameter int unsigned DIV_1HZ  = DEF_DIV_1HZ,
  parameter int unsigned DB_CYC   = DEF_DB_CYC,
  parameter int unsigned HOLD_CYC = DEF_HOLD_CYC,
  parameter int unsigned DIV_FAST = DEF_DIV_FAST
) (
  input  logic CLK,
  input  logic RST,
  input  logic KEY,
  input  logic run,
  output logic tick1hz,
  output logic cnten,
  output logic keydb
);

  localparam int PW = $clog2(DIV_1HZ);
  localparam int unsigned HMAX = (HOLD_CYC > DIV_FAST) ? HOLD_CYC : DIV_FAST;
  localparam int HW = cnt_width(HMAX);
  localparam logic [PW-1:0] P_LAST    = PW'(DIV_1HZ - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0] FAST_LAST = HW'(DIV_FAST - 1);

  set_state_e    state_q, state_d;
  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic          tick_q, tick_d;
  logic          cnten_q, cnten_d;
  logic          pend_q, pend_d;
  logic          key_rise, adv_req, pcnt_restart, pcnt_wrap;

  key_debounce #(
    .DB_CYC (DB_CYC)
  ) u_key_db (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .key_ni  (KEY),
    .keydb_o (keydb),
    .rise_o  (key_rise)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= ST_IDLE;
      pcnt_q  <= '0;
      hcnt_q  <= '0;
      tick_q  <= 1'b0;
      cnten_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pcnt_q  <= pcnt_d;
      hcnt_q  <= hcnt_d;
      tick_q  <= tick_d;
      cnten_q <= cnten_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hcnt_d       = hcnt_q;
    adv_req      = 1'b0;
    pcnt_restart = 1'b0;
    if (!keydb) begin
      state_d = ST_IDLE;
      hcnt_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (key_rise) state_d = ST_PRESS;
        end
        ST_PRESS: begin
          adv_req      = 1'b1;
          pcnt_restart = 1'b1;
          hcnt_d       = '0;
          state_d      = ST_HOLD;
        end
        ST_HOLD: begin
          if (hcnt_q == HOLD_LAST) begin
            adv_req = 1'b1;
            hcnt_d  = '0;
            state_d = ST_REPEAT;
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
        ST_REPEAT: begin
          if (hcnt_q == FAST_LAST) begin
            adv_req = 1'b1;
            hcnt_d  = '0;
          end else begin
            hcnt_d = hcnt_q + HW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign pcnt_wrap = run && (pcnt_q == P_LAST);

  // A tick colliding with an advance is deferred one cycle through pend.
  always_comb begin
    pcnt_d = pcnt_q;
    if (pcnt_restart || pcnt_wrap) begin
      pcnt_d = '0;
    end else if (run) begin
      pcnt_d = pcnt_q + PW'(1);
    end
    tick_d  = pcnt_wrap;
    cnten_d = adv_req | pcnt_wrap | pend_q;
    pend_d  = (adv_req & pcnt_wrap) | (pend_q & (adv_req | pcnt_wrap));
  end

  assign tick1hz = tick_q;
  assign cnten   = cnten_q;

endmodule

// File: tb/tb_sec_tick_gen.sv
// Scoreboard bench for sec_tick_gen with small dividers; expected pulse cycles
// are queued per scenario and a free-running monitor matches DUT pulses.
module tb_sec_tick_gen;

  typedef struct {
    int   c;
    logic v;
  } kdb_ev_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic KEY = 1'b1;
  logic run = 1'b0;
  logic tick1hz, cnten, keydb;

  int      checks   = 0;
  int      failures = 0;
  int      cyc;
  string   scn = "init";
  int      exp_cnten[$];
  int      exp_tick[$];
  kdb_ev_t exp_kdb[$];

  sec_tick_gen #(
    .DIV_1HZ  (10),
    .DB_CYC   (4),
    .HOLD_CYC (20),
    .DIV_FAST (5)
  ) dut (
    .CLK     (CLK),
    .RST     (RST),
    .KEY     (KEY),
    .run     (run),
    .tick1hz (tick1hz),
    .cnten   (cnten),
    .keydb   (keydb)
  );

  always #5 CLK = ~CLK;

  // Rising edges since RST was released.
  always @(posedge CLK or negedge RST) begin
    if (!RST) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic chk(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s %s: got %b, required %b", scn, name, act, req);
    end else begin
      $display("[%s] %s = %b ok", scn, name, act);
    end
  endtask

  task automatic push_c(input int c, input bit is_tick);
    exp_cnten.push_back(c);
    if (is_tick) exp_tick.push_back(c);
  endtask

  task automatic push_k(input int c, input logic v);
    kdb_ev_t ev;
    ev.c = c;
    ev.v = v;
    exp_kdb.push_back(ev);
  endtask

  task automatic monitor_loop();
    logic    kdb_prev;
    int      e;
    kdb_ev_t k;
    kdb_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (!RST) begin
        kdb_prev = 1'b0;
      end else begin
        if (cnten) begin
          checks++;
          if (exp_cnten.size() == 0) begin
            failures++;
            $display("FAIL %s cnten: pulse at cycle %0d, required none", scn, cyc);
          end else begin
            e = exp_cnten.pop_front();
            if (e != cyc) begin
              failures++;
              $display("FAIL %s cnten: pulse at cycle %0d, required cycle %0d", scn, cyc, e);
            end else $display("[%s] cycle %0d cnten ok", scn, cyc);
          end
        end
        if (tick1hz) begin
          checks++;
          if (exp_tick.size() == 0) begin
            failures++;
            $display("FAIL %s tick1hz: pulse at cycle %0d, required none", scn, cyc);
          end else begin
            e = exp_tick.pop_front();
            if (e != cyc) begin
              failures++;
              $display("FAIL %s tick1hz: pulse at cycle %0d, required cycle %0d", scn, cyc, e);
            end else $display("[%s] cycle %0d tick1hz ok", scn, cyc);
          end
        end
        if (keydb !== kdb_prev) begin
          checks++;
          if (exp_kdb.size() == 0) begin
            failures++;
            $display("FAIL %s keydb: changed to %b at cycle %0d, required no change", scn, keydb, cyc);
          end else begin
            k = exp_kdb.pop_front();
            if (k.c != cyc || k.v !== keydb) begin
              failures++;
              $display("FAIL %s keydb: %b at cycle %0d, required %b at cycle %0d", scn, keydb, cyc, k.v, k.c);
            end else $display("[%s] cycle %0d keydb=%b ok", scn, cyc, keydb);
          end
        end
        kdb_prev = keydb;
      end
    end
  endtask

  task automatic start_scn(input string name, input logic run_v);
    RST = 1'b0;
    KEY = 1'b1;
    run = run_v;
    exp_cnten.delete();
    exp_tick.delete();
    exp_kdb.delete();
    scn = name;
    repeat (2) @(negedge CLK);
    #2 RST = 1'b1;
  endtask

  task automatic step_to(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 5000) begin
      @(posedge CLK);
      #1;
      guard++;
    end
    if (cyc < n) begin
      checks++;
      failures++;
      $display("FAIL %s step_to: reached cycle %0d, required %0d", scn, cyc, n);
    end
  endtask

  task automatic chk_empty();
    checks++;
    if (exp_cnten.size() != 0) begin
      failures++;
      $display("FAIL %s cnten_missing: %0d pulses not seen, required cycle %0d", scn, exp_cnten.size(), exp_cnten[0]);
    end
    checks++;
    if (exp_tick.size() != 0) begin
      failures++;
      $display("FAIL %s tick_missing: %0d pulses not seen, required cycle %0d", scn, exp_tick.size(), exp_tick[0]);
    end
    checks++;
    if (exp_kdb.size() != 0) begin
      failures++;
      $display("FAIL %s keydb_missing: %0d changes not seen, required cycle %0d", scn, exp_kdb.size(), exp_kdb[0].c);
    end
  endtask

  task automatic end_scn(input int last);
    step_to(last);
    @(negedge CLK);
    #1;
    chk_empty();
  endtask

  initial begin
    #1 RST = 1'b0;
    #1;
    chk("reset_tick1hz", tick1hz, 1'b0);
    chk("reset_cnten", cnten, 1'b0);
    chk("reset_keydb", keydb, 1'b0);
    fork
      monitor_loop();
    join_none

    // Free run: tick every 10 cycles.
    start_scn("freerun", 1'b1);
    push_c(10, 1); push_c(20, 1); push_c(30, 1); push_c(40, 1); push_c(50, 1);
    end_scn(52);

    // Pause with pcnt held at 3 across cycles 14..27; 7 more counts to wrap.
    start_scn("pause", 1'b1);
    push_c(10, 1); push_c(34, 1); push_c(44, 1);
    step_to(13); run = 1'b0;
    step_to(27); run = 1'b1;
    end_scn(50);

    // Bounce: 2-cycle glitches never survive the debouncer.
    start_scn("bounce", 1'b0);
    for (int k = 0; k < 6; k++) begin
      step_to(10 + 2 * k);
      KEY = (k % 2 == 0) ? 1'b0 : 1'b1;
    end
    end_scn(40);

    // Single press: keydb at +6, cnten at +8, prescaler restarts from the press.
    start_scn("press", 1'b1);
    push_c(10, 1); push_c(20, 1); push_c(21, 0); push_c(31, 1); push_c(41, 1);
    push_k(19, 1'b1); push_k(29, 1'b0);
    step_to(13); KEY = 1'b0;
    step_to(23); KEY = 1'b1;
    end_scn(45);

    // Hold: press at 18, repeats from 38 every 5 until keydb falls at 76.
    start_scn("hold", 1'b0);
    push_c(18, 0);
    for (int c = 38; c <= 73; c += 5) push_c(c, 0);
    push_k(16, 1'b1); push_k(76, 1'b0);
    step_to(10); KEY = 1'b0;
    step_to(70); KEY = 1'b1;
    end_scn(90);

    // Collisions at 20 (press), 40 and 50 (repeats), then async reset mid-REPEAT.
    start_scn("collide", 1'b1);
    push_c(10, 1); push_c(20, 1); push_c(21, 0); push_c(30, 1);
    push_c(40, 1); push_c(41, 0); push_c(45, 0); push_c(50, 1);
    push_k(18, 1'b1);
    step_to(12); KEY = 1'b0;
    step_to(50);
    @(negedge CLK);
    #1;
    chk_empty();
    RST = 1'b0;
    #1;
    chk("async_rst_tick1hz", tick1hz, 1'b0);
    chk("async_rst_cnten", cnten, 1'b0);
    chk("async_rst_keydb", keydb, 1'b0);

    // Nothing pending may leak out of the reset.
    start_scn("post_reset", 1'b0);
    end_scn(30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
    $fatal(1, "simulation timeout");
  end

endmodule
